bcd_display_scan: RTL and testbench

Downstream consumer of the 9-digit binary-to-BCD converter: captures its digits BCD0..BCD8 on a load strobe and drives a time-multiplexed 9-digit seven-segment display. Double-buffered: a load fills a shadow register, which is copied into the displayed register only at a frame boundary, so a frame never mixes old and new digits. Also provides leading-zero blanking, an invalid-digit indication and a decimal point.

---
 rtl/bcd_display_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/bcd_display_scan.sv | 112 +++++++++++
 tb/tb_bcd_display_scan.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// Shared constants and types for the BCD seven-segment scanner.
// Segment patterns are active-high, bit0 = a .. bit6 = g.
package bcd_display_pkg;

   localparam int DIGITS = 9;

   typedef logic [3:0] digit_t;

   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_E   = 7'h79;
   localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to seven-segment decoder, active-high output.
// Codes 10..15 show "E" so a bad converter digit is visible on the display.
module bcd_to_seg7
   import bcd_display_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_E;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_E;
      endcase
   end

endmodule

// File: rtl/bcd_display_scan.sv
// Double-buffered, time-multiplexed 9-digit seven-segment scanner with
// leading-zero blanking, invalid-digit flag and a selectable decimal point.
module bcd_display_scan
   import bcd_display_pkg::*;
#(
   parameter int DIGITS     = bcd_display_pkg::DIGITS,
   parameter int PRESCALE   = 1000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              load,
   input  logic [3:0]        BCD0,
   input  logic [3:0]        BCD1,
   input  logic [3:0]        BCD2,
   input  logic [3:0]        BCD3,
   input  logic [3:0]        BCD4,
   input  logic [3:0]        BCD5,
   input  logic [3:0]        BCD6,
   input  logic [3:0]        BCD7,
   input  logic [3:0]        BCD8,
   input  logic              blank_en,
   input  logic [3:0]        dp_sel,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an,
   output logic              frame_done
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
   localparam logic [3:0]    LAST = 4'(DIGITS - 1);

   logic [PW-1:0]         pcnt;
   logic [3:0]            idx;
   digit_t [DIGITS-1:0]   bcd_in;
   digit_t [DIGITS-1:0]   shadow;
   digit_t [DIGITS-1:0]   active;
   logic                  pending;
   logic                  tick;
   logic                  boundary;
   logic                  frame_wrap;
   digit_t                cur;
   logic                  blank;
   logic [6:0]            seg_raw;
   logic [6:0]            seg_on;
   logic [DIGITS-1:0]     an_on;
   logic                  dp_on;

   assign bcd_in   = {BCD8, BCD7, BCD6, BCD5, BCD4, BCD3, BCD2, BCD1, BCD0};
   assign tick     = (pcnt == PMAX);
   assign boundary = tick && (idx == LAST);

   // A digit is blanked only if it and every more significant digit are zero.
   always_comb begin
      cur   = '0;
      blank = blank_en && (idx != 4'd0);
      for (int i = 0; i < DIGITS; i++) begin
         if (idx == 4'(i)) cur = active[i];
         if ((4'(i) >= idx) && (active[i] != 4'd0)) blank = 1'b0;
      end
   end

   bcd_to_seg7 u_dec (
      .digit (cur),
      .seg   (seg_raw)
   );

   assign seg_on = blank ? SEG_OFF : seg_raw;
   assign an_on  = DIGITS'(1) << idx;
   assign dp_on  = (idx == dp_sel);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         pcnt       <= '0;
         idx        <= '0;
         shadow     <= '0;
         active     <= '0;
         pending    <= 1'b0;
         frame_wrap <= 1'b0;
      end else begin
         pcnt <= tick ? '0 : pcnt + 1'b1;
         if (tick) idx <= (idx == LAST) ? 4'd0 : idx + 4'd1;
         if (load) shadow <= bcd_in;
         // A load on the boundary edge bypasses the shadow entirely.
         if (boundary) begin
            if (load)         active <= bcd_in;
            else if (pending) active <= shadow;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
         frame_wrap <= boundary;
      end
   end

   // frame_done is delayed one extra stage so it lines up with an[0].
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         seg        <= {7{ACTIVE_LOW}};
         dp         <= ACTIVE_LOW;
         an         <= {DIGITS{ACTIVE_LOW}};
         frame_done <= 1'b0;
      end else begin
         seg        <= seg_on ^ {7{ACTIVE_LOW}};
         dp         <= dp_on ^ ACTIVE_LOW;
         an         <= an_on ^ {DIGITS{ACTIVE_LOW}};
         frame_done <= frame_wrap;
      end
   end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed self-checking bench for bcd_display_scan, PRESCALE=4, active-high.
module tb_bcd_display_scan;

   localparam logic [6:0] SEG_TAB [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79, 7'h79};

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load = 1'b0;
   logic [3:0] bcd [9];
   logic       blank_en = 1'b0;
   logic [3:0] dp_sel = 4'd15;
   logic [6:0] seg;
   logic       dp;
   logic [8:0] an;
   logic       frame_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bcd_display_scan #(.DIGITS(9), .PRESCALE(4), .ACTIVE_LOW(1'b0)) dut (
      .Clk        (clk),
      .Rst_n      (rst_n),
      .load       (load),
      .BCD0       (bcd[0]),
      .BCD1       (bcd[1]),
      .BCD2       (bcd[2]),
      .BCD3       (bcd[3]),
      .BCD4       (bcd[4]),
      .BCD5       (bcd[5]),
      .BCD6       (bcd[6]),
      .BCD7       (bcd[7]),
      .BCD8       (bcd[8]),
      .blank_en   (blank_en),
      .dp_sel     (dp_sel),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Digit shown after clock edge number cyc since reset release.
   function automatic int exp_digit();
      return ((cyc - 1) / 4) % 9;
   endfunction

   function automatic logic exp_fd();
      return (cyc > 1) && (((cyc - 1) % 36) == 0);
   endfunction

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_bcd();
      for (int i = 0; i < 9; i++) bcd[i] = 4'd0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      load  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      clear_bcd();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (an !== 9'h000 || seg !== 7'h00 || dp !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_state: an=%h seg=%h dp=%b fd=%b, want all 0", an, seg, dp, frame_done);
      end
      rst_n = 1'b1;
      cyc   = 0;
      while (cyc < 80) begin
         step();
         checks++;
         if (an !== (9'h001 << exp_digit()) || seg !== 7'h3F || frame_done !== exp_fd()) begin
            failures++;
            $display("[TB] FAIL idle_scan cyc=%0d: an=%h seg=%h fd=%b, want an=%h seg=3f fd=%b",
                     cyc, an, seg, frame_done, 9'h001 << exp_digit(), exp_fd());
         end
      end
   endtask

   task automatic test_load();
      logic [6:0] exp;
      do_reset();
      while (cyc < 10) step();
      for (int i = 0; i < 9; i++) bcd[i] = 4'(9 - i);
      load = 1'b1;
      step();
      load = 1'b0;
      clear_bcd();
      while (cyc < 72) begin
         step();
         exp = (cyc <= 36) ? 7'h3F : SEG_TAB[9 - exp_digit()];
         checks++;
         if (seg !== exp || an !== (9'h001 << exp_digit())) begin
            failures++;
            $display("[TB] FAIL load_123456789 cyc=%0d: seg=%h an=%h, want seg=%h an=%h",
                     cyc, seg, an, exp, 9'h001 << exp_digit());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] exp;
      do_reset();
      while (cyc < 4) step();
      for (int i = 0; i < 9; i++) bcd[i] = 4'd1;
      load = 1'b1;
      step();
      load = 1'b0;
      while (cyc < 19) step();
      for (int i = 0; i < 9; i++) bcd[i] = 4'd2;
      load = 1'b1;
      step();
      load = 1'b0;
      clear_bcd();
      while (cyc < 72) begin
         step();
         exp = (cyc <= 36) ? 7'h3F : 7'h5B;
         checks++;
         if (seg !== exp) begin
            failures++;
            $display("[TB] FAIL two_loads cyc=%0d: seg=%h, want %h", cyc, seg, exp);
         end
      end
   endtask

   task automatic test_boundary_load();
      logic [6:0] exp;
      do_reset();
      blank_en = 1'b1;
      while (cyc < 35) begin
         step();
         exp = (exp_digit() == 0) ? 7'h3F : 7'h00;
         checks++;
         if (seg !== exp) begin
            failures++;
            $display("[TB] FAIL blank_zero cyc=%0d: seg=%h, want %h", cyc, seg, exp);
         end
      end
      bcd[1] = 4'd4;
      bcd[0] = 4'd2;
      load = 1'b1;
      step();
      load = 1'b0;
      clear_bcd();
      while (cyc < 72) begin
         step();
         case (exp_digit())
            0:       exp = 7'h5B;
            1:       exp = 7'h66;
            default: exp = 7'h00;
         endcase
         checks++;
         if (seg !== exp || frame_done !== exp_fd()) begin
            failures++;
            $display("[TB] FAIL boundary_load_42 cyc=%0d: seg=%h fd=%b, want seg=%h fd=%b",
                     cyc, seg, frame_done, exp, exp_fd());
         end
      end
      blank_en = 1'b0;
   endtask

   task automatic test_invalid_dp();
      logic [6:0] exp;
      logic       exp_dp;
      do_reset();
      dp_sel = 4'd3;
      bcd[3] = 4'hC;
      while (cyc < 1) step();
      load = 1'b1;
      step();
      load = 1'b0;
      clear_bcd();
      while (cyc < 72) begin
         step();
         exp    = (cyc > 36 && exp_digit() == 3) ? 7'h79 : 7'h3F;
         exp_dp = (exp_digit() == 3);
         checks++;
         if (seg !== exp || dp !== exp_dp) begin
            failures++;
            $display("[TB] FAIL invalid_dp3 cyc=%0d: seg=%h dp=%b, want seg=%h dp=%b",
                     cyc, seg, dp, exp, exp_dp);
         end
      end
      dp_sel = 4'd15;
      while (cyc < 108) begin
         step();
         exp = (exp_digit() == 3) ? 7'h79 : 7'h3F;
         checks++;
         if (seg !== exp || dp !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dp_none cyc=%0d: seg=%h dp=%b, want seg=%h dp=0", cyc, seg, dp, exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      dp_sel = 4'd15;
      for (int i = 0; i < 9; i++) bcd[i] = 4'd5;
      while (cyc < 2) step();
      load = 1'b1;
      step();
      load = 1'b0;
      clear_bcd();
      while (cyc < 22) step();
      checks++;
      if (an !== 9'h020 || seg !== 7'h3F) begin
         failures++;
         $display("[TB] FAIL pre_reset_digit5: an=%h seg=%h, want an=020 seg=3f", an, seg);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (an !== 9'h000 || seg !== 7'h00 || dp !== 1'b0 || frame_done !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset: an=%h seg=%h dp=%b fd=%b, want all 0", an, seg, dp, frame_done);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      while (cyc < 72) begin
         step();
         checks++;
         if (seg !== 7'h3F || an !== (9'h001 << exp_digit())) begin
            failures++;
            $display("[TB] FAIL pending_lost cyc=%0d: seg=%h an=%h, want seg=3f an=%h",
                     cyc, seg, an, 9'h001 << exp_digit());
         end
      end
   endtask

   initial begin
      clear_bcd();
      test_reset();
      test_load();
      test_back_to_back();
      test_boundary_load();
      test_invalid_dp();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
